// File: rtl/bolme_birimi_if.sv
// bolme_birimi_if: YURUT stage <-> divider bundle.
// master = pipeline side, slave = divider side.
interface bolme_birimi_if #(
  parameter int XLEN = 32
);
  logic            basla_i;
  logic [1:0]      islem_i;
  logic [XLEN-1:0] bolunen_i;
  logic [XLEN-1:0] bolen_i;
  logic            iptal_i;
  logic [XLEN-1:0] sonuc_o;
  logic            gecerli_o;
  logic            hazir_o;

  modport master (
    output basla_i,
    output islem_i,
    output bolunen_i,
    output bolen_i,
    output iptal_i,
    input  sonuc_o,
    input  gecerli_o,
    input  hazir_o
  );

  modport slave (
    input  basla_i,
    input  islem_i,
    input  bolunen_i,
    input  bolen_i,
    input  iptal_i,
    output sonuc_o,
    output gecerli_o,
    output hazir_o
  );
endinterface

// File: rtl/bolme_birimi.sv
// bolme_birimi: radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU).
// BOLME_HIZLI_EN: divide-by-zero and signed overflow finish in one cycle.
module bolme_birimi #(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bolme_birimi_if.slave bb
);

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HESAPLA = 2'd1,
    BITTI   = 2'd2
  } durum_e;

  durum_e          durum_q, durum_d;
  logic [1:0]      islem_q, islem_d;
  logic [XLEN-1:0] bolen_q, bolen_d;
  logic [XLEN-1:0] bolum_q, bolum_d;
  logic [XLEN:0]   kalan_q, kalan_d;
  logic [4:0]      sayac_q, sayac_d;
  logic            bisaret_q, bisaret_d;
  logic            kisaret_q, kisaret_d;
  logic [XLEN-1:0] sonuc_q, sonuc_d;

  logic            hazir;
  logic            gecerli;

  logic            imzali_gir;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  assign imzali_gir = ~bb.islem_i[0];
  assign a_neg      = imzali_gir & bb.bolunen_i[XLEN-1];
  assign b_neg      = imzali_gir & bb.bolen_i[XLEN-1];
  assign a_abs      = a_neg ? -bb.bolunen_i : bb.bolunen_i;
  assign b_abs      = b_neg ? -bb.bolen_i : bb.bolen_i;

  // One restoring step; the quotient register shifts dividend bits out
  // at the top while quotient bits enter at the bottom.
  logic [XLEN+1:0] deneme;
  logic [XLEN-1:0] bolum_yeni;
  logic [XLEN:0]   kalan_yeni;

  assign deneme     = {kalan_q, bolum_q[XLEN-1]} - {2'b00, bolen_q};
  assign bolum_yeni = {bolum_q[XLEN-2:0], ~deneme[XLEN+1]};
  assign kalan_yeni = deneme[XLEN+1]
                    ? {kalan_q[XLEN-1:0], bolum_q[XLEN-1]}
                    : deneme[XLEN:0];

  // Sign fix-up on the final step. A zero divisor already yields an
  // all-ones quotient magnitude, which must not be negated.
  logic            imzali_q;
  logic            bolen_sifir_q;
  logic [XLEN-1:0] bolum_son;
  logic [XLEN-1:0] kalan_son;
  logic [XLEN-1:0] son;

  assign imzali_q      = ~islem_q[0];
  assign bolen_sifir_q = (bolen_q == '0);
  assign bolum_son     = (imzali_q & bisaret_q & ~bolen_sifir_q)
                       ? -bolum_yeni : bolum_yeni;
  assign kalan_son     = (imzali_q & kisaret_q & (|kalan_yeni[XLEN-1:0]))
                       ? -kalan_yeni[XLEN-1:0] : kalan_yeni[XLEN-1:0];
  assign son           = islem_q[1] ? kalan_son : bolum_son;

`ifdef BOLME_HIZLI_EN
  logic            b_sifir;
  logic            tasma;
  logic            ozel;
  logic [XLEN-1:0] ozel_sonuc;

  assign b_sifir = (bb.bolen_i == '0);
  assign tasma   = imzali_gir
                 & (bb.bolunen_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (&bb.bolen_i);
  assign ozel    = b_sifir | tasma;

  // Special results straight from the operands; overflow's quotient
  // equals the dividend itself.
  always_comb begin
    ozel_sonuc = '0;
    if (b_sifir) begin
      ozel_sonuc = bb.islem_i[1] ? bb.bolunen_i : '1;
    end else begin
      ozel_sonuc = bb.islem_i[1] ? '0 : bb.bolunen_i;
    end
  end
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    durum_d   = durum_q;
    islem_d   = islem_q;
    bolen_d   = bolen_q;
    bolum_d   = bolum_q;
    kalan_d   = kalan_q;
    sayac_d   = sayac_q;
    bisaret_d = bisaret_q;
    kisaret_d = kisaret_q;
    sonuc_d   = sonuc_q;
    hazir     = 1'b1;
    gecerli   = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        hazir = ~bb.basla_i | bb.iptal_i;
        if (bb.basla_i && !bb.iptal_i) begin
          islem_d   = bb.islem_i;
          bolum_d   = a_abs;
          bolen_d   = b_abs;
          bisaret_d = bb.bolunen_i[XLEN-1] ^ bb.bolen_i[XLEN-1];
          kisaret_d = bb.bolunen_i[XLEN-1];
          kalan_d   = '0;
          sayac_d   = '0;
`ifdef BOLME_HIZLI_EN
          if (ozel) begin
            sonuc_d = ozel_sonuc;
            durum_d = BITTI;
          end else begin
            durum_d = HESAPLA;
          end
`else
          durum_d   = HESAPLA;
`endif
        end
      end
      HESAPLA: begin
        hazir = bb.iptal_i;
        if (bb.iptal_i) begin
          durum_d = BOSTA;
        end else begin
          bolum_d = bolum_yeni;
          kalan_d = kalan_yeni;
          sayac_d = sayac_q + 5'd1;
          if (sayac_q == 5'd31) begin
            sonuc_d = son;
            durum_d = BITTI;
          end
        end
      end
      BITTI: begin
        hazir   = 1'b1;
        gecerli = ~bb.iptal_i;
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q   <= BOSTA;
      islem_q   <= '0;
      bolen_q   <= '0;
      bolum_q   <= '0;
      kalan_q   <= '0;
      sayac_q   <= '0;
      bisaret_q <= 1'b0;
      kisaret_q <= 1'b0;
      sonuc_q   <= '0;
    end else begin
      durum_q   <= durum_d;
      islem_q   <= islem_d;
      bolen_q   <= bolen_d;
      bolum_q   <= bolum_d;
      kalan_q   <= kalan_d;
      sayac_q   <= sayac_d;
      bisaret_q <= bisaret_d;
      kisaret_q <= kisaret_d;
      sonuc_q   <= sonuc_d;
    end
  end

  assign bb.sonuc_o   = sonuc_q;
  assign bb.gecerli_o = gecerli;
  assign bb.hazir_o   = hazir;

endmodule

// File: tb/tb_bolme_birimi.sv
// tb_bolme_birimi: bolme_birimi against an arithmetic reference.
// Follows BOLME_HIZLI_EN for the expected special-case latency.
module tb_bolme_birimi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   mis = 0;

  always #5 clk = ~clk;

  bolme_birimi_if #(.XLEN(32)) bb ();

  bolme_birimi #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bb    (bb)
  );

  function automatic logic [31:0] ref_f(input logic [1:0] isl,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'd0) return isl[1] ? a : 32'hFFFF_FFFF;
    if (!isl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return isl[1] ? 32'd0 : 32'h8000_0000;
    case (isl)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int lat_f(input logic [1:0] isl,
                               input logic [31:0] a,
                               input logic [31:0] b);
`ifdef BOLME_HIZLI_EN
    if (b == 32'd0) return 1;
    if (!isl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a started op yields its result a fixed number of
  // cycles later; abort or reset drops it.
  int          m_left;
  bit          m_bitti;
  logic [31:0] m_res;
  logic [31:0] m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_bitti <= 1'b0;
      m_res   <= '0;
      m_last  <= '0;
    end else if (m_bitti) begin
      m_bitti <= 1'b0;
    end else if (m_left > 0) begin
      if (bb.iptal_i) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left  <= 0;
        m_bitti <= 1'b1;
        m_last  <= m_res;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (bb.basla_i && !bb.iptal_i) begin
      m_res <= ref_f(bb.islem_i, bb.bolunen_i, bb.bolen_i);
      if (lat_f(bb.islem_i, bb.bolunen_i, bb.bolen_i) == 1) begin
        m_bitti <= 1'b1;
        m_last  <= ref_f(bb.islem_i, bb.bolunen_i, bb.bolen_i);
      end else begin
        m_left <= lat_f(bb.islem_i, bb.bolunen_i, bb.bolen_i) - 1;
      end
    end
  end

  // Per-cycle compare of all outputs against the reference.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("gecerli", 32'(bb.gecerli_o),
          32'(m_bitti && !bb.iptal_i));
      chk("hazir", 32'(bb.hazir_o),
          32'(bb.iptal_i || m_bitti || (m_left == 0 && !bb.basla_i)));
      chk("sonuc", bb.sonuc_o, m_last);
    end
  end

  task automatic op(input logic [1:0] isl, input logic [31:0] a,
                    input logic [31:0] b, input bit hold,
                    input logic [31:0] exp, input int exp_lat,
                    input string nm);
    int n = 0;
    bb.basla_i   = 1'b1;
    bb.islem_i   = isl;
    bb.bolunen_i = a;
    bb.bolen_i   = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bb.gecerli_o && n < 60);
    chk({nm, " done"}, 32'(bb.gecerli_o), 32'd1);
    chk({nm, " lat"}, 32'(n), 32'(exp_lat));
    chk({nm, " sonuc"}, bb.sonuc_o, exp);
    if (!hold) bb.basla_i = 1'b0;
  endtask

  int          lsp;
  bit          hold_prev;
  bit          hold;
  logic [1:0]  isl;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
`ifdef BOLME_HIZLI_EN
    lsp = 1;
`else
    lsp = 33;
`endif
    bb.basla_i   = 1'b0;
    bb.islem_i   = 2'd0;
    bb.bolunen_i = '0;
    bb.bolen_i   = '0;
    bb.iptal_i   = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst gecerli", 32'(bb.gecerli_o), 32'd0);
    chk("rst sonuc", bb.sonuc_o, 32'd0);
    chk("rst hazir", 32'(bb.hazir_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); op(2'd1, 32'd100, 32'd7, 0, 32'd14, 33, "divu");
    @(negedge clk); op(2'd3, 32'd100, 32'd7, 0, 32'd2, 33, "remu");
    @(negedge clk); op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 33, "div");
    @(negedge clk); op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 33, "rem");
    @(negedge clk); op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 32'd1, 33, "rem2");
    @(negedge clk); op(2'd0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, lsp, "div0");
    @(negedge clk); op(2'd3, 32'd5, 32'd0, 0, 32'd5, lsp, "remu0");
    @(negedge clk); op(2'd2, 32'hFFFF_FFF9, 32'd0, 0, 32'hFFFF_FFF9, lsp, "rem0");
    @(negedge clk); op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, lsp, "ovf");
    @(negedge clk); op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, lsp, "ovfrem");

    @(negedge clk); op(2'd1, 32'd10, 32'd3, 1, 32'd3, 33, "b2b1");
    op(2'd1, 32'd9, 32'd3, 0, 32'd3, 34, "b2b2");

    @(negedge clk);
    bb.basla_i   = 1'b1;
    bb.islem_i   = 2'd1;
    bb.bolunen_i = 32'd1000;
    bb.bolen_i   = 32'd3;
    repeat (10) @(negedge clk);
    bb.iptal_i = 1'b1;
    bb.basla_i = 1'b0;
    #1;
    chk("iptal hazir", 32'(bb.hazir_o), 32'd1);
    chk("iptal gecerli", 32'(bb.gecerli_o), 32'd0);
    @(negedge clk);
    bb.iptal_i = 1'b0;
    repeat (40) @(negedge clk);
    bb.basla_i = 1'b1;
    bb.iptal_i = 1'b1;
    @(negedge clk);
    bb.basla_i = 1'b0;
    bb.iptal_i = 1'b0;
    repeat (3) @(negedge clk);
    op(2'd1, 32'd20, 32'd4, 0, 32'd5, 33, "after iptal");

    @(negedge clk);
    bb.basla_i   = 1'b1;
    bb.islem_i   = 2'd1;
    bb.bolunen_i = 32'd77;
    bb.bolen_i   = 32'd5;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n      = 1'b0;
    bb.basla_i = 1'b0;
    #1;
    chk("midrst gecerli", 32'(bb.gecerli_o), 32'd0);
    chk("midrst sonuc", bb.sonuc_o, 32'd0);
    chk("midrst hazir", 32'(bb.hazir_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    hold_prev = 1'b0;
    for (int i = 0; i < 150; i++) begin
      isl = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'($urandom_range(1, 1000));
        4: rb = -32'($urandom_range(1, 50));
        default: ;
      endcase
      hold = ($urandom_range(0, 3) == 0);
      if (!hold_prev) repeat ($urandom_range(1, 3)) @(negedge clk);
      op(isl, ra, rb, hold, ref_f(isl, ra, rb),
         lat_f(isl, ra, rb) + (hold_prev ? 1 : 0), "rnd");
      hold_prev = hold;
    end
    bb.basla_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
